// File: rtl/tug_playfield.sv
// ---------------------------------------------------------------------------
// tug_playfield
//   Upstream playfield stage of the tug-of-war game. Each raw player key is
//   synchronized (2 flops), optionally debounced, rising-edge detected and
//   registered into a single-cycle press pulse (L / R). Every accepted press
//   moves the one-hot lit position one step: L toward led[9], R toward
//   led[1]. A press taken while already on the end light wins. The stage
//   then freezes with all lights off and done high until reset.
//
//   Optional feature macro: PLAYFIELD_DEBOUNCE_EN
//     defined   -> each synchronized key passes through a stable-count
//                  filter of DEBOUNCE_CYCLES cycles before edge detection.
//     undefined -> the synchronized level feeds the edge detector directly.
//
// Parameters
//   START_POS        light index (1..9) loaded on reset
//   DEBOUNCE_CYCLES  stable-cycle count (1..255), debounce build only
//
// Ports
//   clk    in   system clock, all state on posedge
//   reset  in   asynchronous active-low reset
//   key_l  in   raw left key, active-high, asynchronous
//   key_r  in   raw right key, active-high, asynchronous
//   led    out  [9:1] one-hot position, all zero once done
//   L      out  registered single-cycle left-press pulse
//   R      out  registered single-cycle right-press pulse
//   done   out  high from the cycle after the winning press until reset;
//               this is the decoded FSM state (PLAY = 0, DONE = 1)
//
// Handshake: there is no back-pressure. L/R are one-cycle qualifiers that
// are valid in the same cycle as the led value they were taken against;
// downstream samples LED9 & L or LED1 & R in that cycle.
// ---------------------------------------------------------------------------
module tug_playfield #(
  parameter int START_POS       = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l,
  input  logic       key_r,
  output logic [9:1] led,
  output logic       L,
  output logic       R,
  output logic       done
);

  typedef enum logic {
    S_PLAY = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam logic [9:1] LED_RESET = 9'(1 << (START_POS - 1));

  // Elaboration-time guard on parameter ranges.
  if (START_POS < 1 || START_POS > 9) begin : g_bad_start_pos
    $error("tug_playfield: START_POS must be in 1..9");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("tug_playfield: DEBOUNCE_CYCLES must be in 1..255");
  end

  // Bit 1 = left key, bit 0 = right key throughout the input path.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;
  logic [1:0] w_level;
  logic [1:0] w_edge;
  state_t     r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {key_l, key_r};
      r_sync2 <= r_sync1;
    end
  end

`ifdef PLAYFIELD_DEBOUNCE_EN
  logic [7:0] r_db_cnt [2];
  logic [1:0] r_db_level;

  // The filtered level follows the synchronized level only after they have
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
  // restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_level <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_db_cnt[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_db_level[k]) begin
          if (r_db_cnt[k] == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_db_level[k] <= r_sync2[k];
            r_db_cnt[k]   <= 8'd0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + 8'd1;
          end
        end else begin
          r_db_cnt[k] <= 8'd0;
        end
      end
    end
  end

  assign w_level = r_db_level;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 2'b00;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_edge = w_level & ~r_prev;

  // Movement acts on the pulse currently on L/R, so the winning pulse is
  // seen downstream while led still shows the end light.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_PLAY;
      led     <= LED_RESET;
      L       <= 1'b0;
      R       <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          L <= w_edge[1];
          R <= w_edge[0];
          if (L && !R) begin
            if (led[9]) begin
              r_state <= S_DONE;
              led     <= 9'b0;
              done    <= 1'b1;
              L       <= 1'b0;
              R       <= 1'b0;
            end else begin
              led <= led << 1;
            end
          end else if (R && !L) begin
            if (led[1]) begin
              r_state <= S_DONE;
              led     <= 9'b0;
              done    <= 1'b1;
              L       <= 1'b0;
              R       <= 1'b0;
            end else begin
              led <= led >> 1;
            end
          end
        end
        S_DONE: begin
          led  <= 9'b0;
          L    <= 1'b0;
          R    <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          r_state <= S_PLAY;
          led     <= LED_RESET;
          L       <= 1'b0;
          R       <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_playfield.sv
module tb_tug_playfield;

  localparam int START_POS = 5;
  localparam int DB        = 4;
`ifdef PLAYFIELD_DEBOUNCE_EN
  localparam int X = DB;
`else
  localparam int X = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       key_l = 1'b0;
  logic       key_r = 1'b0;
  logic [9:1] led;
  logic       L;
  logic       R;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  // {led, L, R, done}
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  tug_playfield #(
    .START_POS      (START_POS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key_l(key_l),
    .key_r(key_r),
    .led  (led),
    .L    (L),
    .R    (R),
    .done (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [9:1] onehot(input int p);
    logic [9:1] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Advance one edge; everything samples/drives 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    key_l = 1'b0;
    key_r = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One press: keys high for 2+X samples, then low long enough to re-arm.
  task automatic do_press(input logic kl, input logic kr,
                          output int nl, output int nr, output int nboth,
                          output logic [9:1] led_l, output logic [9:1] led_r);
    nl    = 0;
    nr    = 0;
    nboth = 0;
    led_l = '0;
    led_r = '0;
    key_l = kl;
    key_r = kr;
    for (int c = 0; c < 10 + 2 * X; c++) begin
      tick();
      if (c == 1 + X) begin
        key_l = 1'b0;
        key_r = 1'b0;
      end
      if (L) begin
        nl++;
        led_l = led;
      end
      if (R) begin
        nr++;
        led_r = led;
      end
      if (L && R) nboth++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] exp;
    key_l = 1'b0;
    key_r = 1'b0;
    reset = 1'b0;
    exp   = {onehot(START_POS), 3'b000};
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({led, L, R, done} !== exp) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%b required=%b", c, {led, L, R, done}, exp);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({led, L, R, done} !== exp) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%b required=%b", c, {led, L, R, done}, exp);
      end
    end
  endtask

  task automatic test_single_press();
    logic       exp_l;
    logic [9:1] exp_led;
    apply_reset();
    key_l = 1'b1;
    for (int c = 0; c <= 12 + 2 * X; c++) begin
      tick();
      if (c == 5 + X) key_l = 1'b0;
      exp_l   = (c == 2 + X);
      exp_led = (c >= 3 + X) ? onehot(6) : onehot(5);
      n_cmp++;
      if (L !== exp_l || R !== 1'b0 || led !== exp_led || done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_press c=%0d got L=%b R=%b led=%b done=%b required L=%b R=0 led=%b done=0",
                 c, L, R, led, done, exp_l, exp_led);
      end
    end
  endtask

  task automatic test_left_win();
    int nl, nr, nb;
    logic [9:1] ll, lr;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_press(1'b1, 1'b0, nl, nr, nb, ll, lr);
      n_cmp++;
      if (nl != 1 || nr != 0 || led !== onehot(5 + i) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL left_walk i=%0d got nl=%0d nr=%0d led=%b done=%b required nl=1 nr=0 led=%b done=0",
                 i, nl, nr, led, done, onehot(5 + i));
      end
    end
    do_press(1'b1, 1'b0, nl, nr, nb, ll, lr);
    n_cmp++;
    if (nl != 1 || ll !== onehot(9)) begin
      n_fail++;
      $display("FAIL left_win_pulse got nl=%0d led_at_L=%b required nl=1 led_at_L=%b", nl, ll, onehot(9));
    end
    n_cmp++;
    if (led !== 9'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL left_win_done got led=%b done=%b required led=0 done=1", led, done);
    end
    do_press(1'b0, 1'b1, nl, nr, nb, ll, lr);
    n_cmp++;
    if (nr != 0 || nl != 0 || led !== 9'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_frozen got nl=%0d nr=%0d led=%b done=%b required nl=0 nr=0 led=0 done=1",
               nl, nr, led, done);
    end
  endtask

  task automatic test_tie();
    int nl, nr, nb;
    logic [9:1] ll, lr;
    apply_reset();
    do_press(1'b1, 1'b1, nl, nr, nb, ll, lr);
    n_cmp++;
    if (nb != 1 || nl != 1 || nr != 1 || led !== onehot(START_POS) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL tie got both=%0d nl=%0d nr=%0d led=%b done=%b required both=1 nl=1 nr=1 led=%b done=0",
               nb, nl, nr, led, done, onehot(START_POS));
    end
  endtask

  task automatic test_right_win_reset();
    int nl, nr, nb;
    logic [9:1] ll, lr;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_press(1'b0, 1'b1, nl, nr, nb, ll, lr);
      n_cmp++;
      if (nr != 1 || led !== onehot(5 - i)) begin
        n_fail++;
        $display("FAIL right_walk i=%0d got nr=%0d led=%b required nr=1 led=%b", i, nr, led, onehot(5 - i));
      end
    end
    do_press(1'b0, 1'b1, nl, nr, nb, ll, lr);
    n_cmp++;
    if (nr != 1 || lr !== onehot(1) || led !== 9'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL right_win got nr=%0d led_at_R=%b led=%b done=%b required nr=1 led_at_R=%b led=0 done=1",
               nr, lr, led, done, onehot(1));
    end
    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({led, L, R, done} !== {onehot(START_POS), 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset got=%b required=%b", {led, L, R, done}, {onehot(START_POS), 3'b000});
    end
    tick();
    reset = 1'b1;
    do_press(1'b1, 1'b0, nl, nr, nb, ll, lr);
    n_cmp++;
    if (nl != 1 || led !== onehot(START_POS + 1) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_after_reset got nl=%0d led=%b done=%b required nl=1 led=%b done=0",
               nl, led, done, onehot(START_POS + 1));
    end
  endtask

`ifdef PLAYFIELD_DEBOUNCE_EN
  task automatic test_debounce();
    int n_pulse;
    int first_c;
    apply_reset();
    n_pulse = 0;
    key_l   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 2) key_l = 1'b0;
      if (L) n_pulse++;
    end
    n_cmp++;
    if (n_pulse != 0 || led !== onehot(START_POS)) begin
      n_fail++;
      $display("FAIL debounce_glitch got pulses=%0d led=%b required pulses=0 led=%b",
               n_pulse, led, onehot(START_POS));
    end
    first_c = -1;
    key_l   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 5) key_l = 1'b0;
      if (L && first_c < 0) first_c = c;
    end
    n_cmp++;
    if (first_c != 2 + DB) begin
      n_fail++;
      $display("FAIL debounce_latency got first_pulse_edge=%0d required %0d", first_c, 2 + DB);
    end
  endtask
`endif

`ifndef PLAYFIELD_DEBOUNCE_EN
  // Reference model: pulse = key seen high two samples ago after being low
  // the sample before; each pulse moves the light one step, the end light
  // plus a same-direction pulse ends the game.
  task automatic test_random();
    int         m_pos;
    logic       m_done;
    logic       e_l, e_r;
    logic [3:0] hl, hr;
    logic [11:0] exp, got;
    apply_reset();
    m_pos  = START_POS;
    m_done = 1'b0;
    e_l    = 1'b0;
    e_r    = 1'b0;
    hl     = '0;
    hr     = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({led, L, R, done} !== {onehot(START_POS), 3'b000}) begin
          n_fail++;
          $display("FAIL random_reset cyc=%0d got=%b required=%b", cyc, {led, L, R, done},
                   {onehot(START_POS), 3'b000});
        end
        reset  = 1'b1;
        m_pos  = START_POS;
        m_done = 1'b0;
        e_l    = 1'b0;
        e_r    = 1'b0;
        hl     = '0;
        hr     = '0;
      end
      if ($urandom_range(0, 1) == 0) key_l = ~key_l;
      if ($urandom_range(0, 3) == 0) key_r = ~key_r;
      tick();
      if (!m_done) begin
        if (e_l && !e_r) begin
          if (m_pos == 9) m_done = 1'b1;
          else m_pos = m_pos + 1;
        end else if (e_r && !e_l) begin
          if (m_pos == 1) m_done = 1'b1;
          else m_pos = m_pos - 1;
        end
      end
      hl  = {hl[2:0], key_l};
      hr  = {hr[2:0], key_r};
      e_l = !m_done && hl[2] && !hl[3];
      e_r = !m_done && hr[2] && !hr[3];
      exp_q.push_back({(m_done ? 9'b0 : onehot(m_pos)), e_l, e_r, m_done});
      exp = exp_q.pop_front();
      got = {led, L, R, done};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc=%0d got {led,L,R,done}=%b required %b", cyc, got, exp);
      end
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_press();
    test_left_win();
    test_tie();
    test_right_win_reset();
`ifdef PLAYFIELD_DEBOUNCE_EN
    test_debounce();
`else
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
